ecc_scalar_mult_seq: RTL and testbench

ECC_SCALAR_MULT_SEQ -- requirements
Module: ecc_scalar_mult_seq

---
 rtl/ecc_scalar_mult_seq_pkg.sv | 30 +++
 rtl/ecc_scalar_mult_seq_modinv.sv | 71 +++++++
 rtl/ecc_scalar_mult_seq.sv | 178 +++++++++++++++++
 tb/tb_ecc_scalar_mult_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ecc_scalar_mult_seq_pkg.sv
// Shared types and helpers for the sequential ECC scalar multiplier.
//   point_t  : affine point, (0,0) stands for the point at infinity
//   state_t  : top-level FSM states
//   mod_nn   : remainder forced into [0, md-1]
// Reductions run at MOD_W, so NR_BITI must not exceed DEF_NR_BITI.
package ecc_scalar_mult_seq_pkg;

   localparam int DEF_NR_BITI = 32;
   localparam int DEF_K_BITS  = 6;
   localparam int DEF_COEF_A  = 4;
   localparam int MOD_W       = 2 * DEF_NR_BITI;

   typedef logic signed [MOD_W-1:0] wide_t;

   typedef struct packed {
      logic signed [DEF_NR_BITI-1:0] coord_x;
      logic signed [DEF_NR_BITI-1:0] coord_y;
   } point_t;

   typedef enum logic [2:0] {IDLE, CHECK, DBL, ADD, PREP, INV, FIN, DONE} state_t;

   // '%' keeps the dividend's sign; fold negative remainders back into range.
   function automatic wide_t mod_nn(input wide_t v, input wide_t md);
      wide_t r;
      r = v % md;
      if (r < 0) r = r + md;
      return r;
   endfunction

endpackage

// File: rtl/ecc_scalar_mult_seq_modinv.sv
// ecc_modinv: modular inverse by Fermat, inv = a^(m-2) mod m (m prime).
//   clk, rst   : clock, async active-high reset
//   start      : loads a and m, begins exponentiation
//   a, m       : operand in [0, m-1] and prime modulus
//   done       : one-cycle pulse exactly NR_BITI+1 cycles after start
//   inv        : result, held until the next start
// One exponent bit per cycle, MSB first; leading zero bits just square 1.
module ecc_modinv
   import ecc_scalar_mult_seq_pkg::*;
#(
   parameter int NR_BITI = DEF_NR_BITI
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic signed [NR_BITI-1:0] a,
   input  logic signed [NR_BITI-1:0] m,
   output logic                      done,
   output logic signed [NR_BITI-1:0] inv
);
   localparam int W2 = 2 * NR_BITI;
   localparam int CW = $clog2(NR_BITI + 1);
   typedef logic signed [NR_BITI-1:0] crd_t;
   typedef logic signed [W2-1:0]      dbl_t;

   function automatic crd_t mulm(input crd_t x, input crd_t y, input crd_t md);
      return crd_t'(mod_nn(wide_t'(dbl_t'(x) * dbl_t'(y)), wide_t'(md)));
   endfunction

   crd_t               base_q, m_q, acc_q, sq, nx;
   logic [NR_BITI-1:0] e_q;
   logic [CW-1:0]      cnt_q;
   logic               run_q, done_q;

   assign sq = mulm(acc_q, acc_q, m_q);
   assign nx = e_q[NR_BITI-1] ? mulm(sq, base_q, m_q) : sq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q <= '0;
         m_q    <= '0;
         acc_q  <= '0;
         e_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            base_q <= a;
            m_q    <= m;
            e_q    <= NR_BITI'(m - 2);
            acc_q  <= crd_t'(1);
            cnt_q  <= CW'(NR_BITI);
            run_q  <= 1'b1;
         end else if (run_q) begin
            acc_q <= nx;
            e_q   <= e_q << 1;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign inv  = acc_q;

endmodule

// File: rtl/ecc_scalar_mult_seq.sv
// ecc_scalar_mult_seq: R = k*P on y^2 = x^3 + COEF_A*x + b (mod m),
// left-to-right double-and-add over affine coordinates.
//   clk, rst       : clock, async active-high reset
//   start, k       : request and unsigned scalar (taken only in IDLE)
//   px, py, m      : base point and prime modulus, captured with start
//   busy, done     : operation in flight / one-cycle result strobe
//   err            : modulus below 3, valid with done
//   rx, ry         : result, held after done until the next start
// The inversion is launched from the DBL/ADD dispatch cycle so that it
// overlaps PREP; INV then waits for ecc_modinv and FIN closes the chord.
module ecc_scalar_mult_seq
   import ecc_scalar_mult_seq_pkg::*;
#(
   parameter int NR_BITI = DEF_NR_BITI,
   parameter int K_BITS  = DEF_K_BITS,
   parameter int COEF_A  = DEF_COEF_A
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [K_BITS-1:0]         k,
   input  logic signed [NR_BITI-1:0] px,
   input  logic signed [NR_BITI-1:0] py,
   input  logic signed [NR_BITI-1:0] m,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic signed [NR_BITI-1:0] rx,
   output logic signed [NR_BITI-1:0] ry
);
   localparam int W2 = 2 * NR_BITI;
   localparam int IW = (K_BITS > 1) ? $clog2(K_BITS) : 1;
   typedef logic signed [NR_BITI-1:0] crd_t;
   typedef logic signed [W2-1:0]      dbl_t;

   function automatic crd_t redm(input dbl_t v, input crd_t md);
      return crd_t'(mod_nn(wide_t'(v), wide_t'(md)));
   endfunction

   function automatic crd_t mulm(input crd_t x, input crd_t y, input crd_t md);
      return redm(dbl_t'(x) * dbl_t'(y), md);
   endfunction

   state_t            state, nxt, ret_q;
   logic [K_BITS-1:0] k_q;
   logic [IW-1:0]     i_q;
   crd_t              px_q, py_q, m_q, rx_q, ry_q, num_q;
   crd_t              num_c, den_c, rnx, rny, inv, x2, lam, x3, y3;
   logic              err_q, r_ld, inv_go, inv_done, cmpl, opa, adv;
   logic              r_inf, p_inf;

   ecc_modinv #(.NR_BITI(NR_BITI)) u_inv (
      .clk   (clk),
      .rst   (rst),
      .start (inv_go),
      .a     (den_c),
      .m     (m_q),
      .done  (inv_done),
      .inv   (inv)
   );

   assign r_inf = (rx_q == '0) && (ry_q == '0);
   assign p_inf = (px_q == '0) && (py_q == '0);

   // Chord/tangent completion; x2 is R.x itself when doubling.
   assign x2  = (ret_q == ADD) ? px_q : rx_q;
   assign lam = mulm(num_q, inv, m_q);
   assign x3  = redm(dbl_t'(mulm(lam, lam, m_q)) - dbl_t'(rx_q) - dbl_t'(x2), m_q);
   assign y3  = redm(dbl_t'(lam) * dbl_t'(redm(dbl_t'(rx_q) - dbl_t'(x3), m_q))
                     - dbl_t'(ry_q), m_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt    = state;
      r_ld   = 1'b0;
      rnx    = rx_q;
      rny    = ry_q;
      inv_go = 1'b0;
      num_c  = '0;
      den_c  = '0;
      cmpl   = 1'b0;
      opa    = 1'b0;
      adv    = 1'b0;
      case (state)
         IDLE:  if (start) nxt = CHECK;
         CHECK: nxt = (m_q < 3) ? DONE : DBL;
         DBL: begin
            if (r_inf) begin
               cmpl = 1'b1;
            end else if (ry_q == '0) begin
               r_ld = 1'b1; rnx = '0; rny = '0; cmpl = 1'b1;
            end else begin
               num_c  = redm(dbl_t'(3) * dbl_t'(mulm(rx_q, rx_q, m_q)) + dbl_t'(COEF_A), m_q);
               den_c  = redm(dbl_t'(2) * dbl_t'(ry_q), m_q);
               inv_go = 1'b1;
               nxt    = PREP;
            end
         end
         ADD: begin
            opa = 1'b1;
            if (r_inf) begin
               r_ld = 1'b1; rnx = px_q; rny = py_q; cmpl = 1'b1;
            end else if (p_inf) begin
               cmpl = 1'b1;
            end else if ((rx_q == px_q) && (ry_q == redm(dbl_t'(m_q) - dbl_t'(py_q), m_q))) begin
               r_ld = 1'b1; rnx = '0; rny = '0; cmpl = 1'b1;
            end else begin
               num_c  = redm(dbl_t'(py_q) - dbl_t'(ry_q), m_q);
               den_c  = redm(dbl_t'(px_q) - dbl_t'(rx_q), m_q);
               inv_go = 1'b1;
               nxt    = PREP;
            end
         end
         PREP: nxt = INV;
         INV:  if (inv_done) nxt = FIN;
         FIN: begin
            r_ld = 1'b1; rnx = x3; rny = y3;
            cmpl = 1'b1; opa = (ret_q == ADD);
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // A finished doubling is followed by the add when the bit is set;
      // otherwise move to the next lower bit or finish after bit 0.
      if (cmpl) begin
         if (!opa && k_q[i_q])  nxt = ADD;
         else if (i_q == '0)    nxt = DONE;
         else begin             nxt = DBL; adv = 1'b1; end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q   <= '0;
         px_q  <= '0;
         py_q  <= '0;
         m_q   <= '0;
         rx_q  <= '0;
         ry_q  <= '0;
         num_q <= '0;
         i_q   <= '0;
         err_q <= 1'b0;
         ret_q <= IDLE;
      end else begin
         if (state == IDLE && start) begin
            k_q   <= k;
            px_q  <= px;
            py_q  <= py;
            m_q   <= m;
            rx_q  <= '0;
            ry_q  <= '0;
            i_q   <= IW'(K_BITS - 1);
            err_q <= 1'b0;
         end
         if (state == CHECK && m_q < 3) err_q <= 1'b1;
         if (r_ld) begin
            rx_q <= rnx;
            ry_q <= rny;
         end
         if (adv) i_q <= i_q - IW'(1);
         if (inv_go) begin
            ret_q <= state;
            num_q <= num_c;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign err  = err_q;
   assign rx   = rx_q;
   assign ry   = ry_q;

endmodule

// File: tb/tb_ecc_scalar_mult_seq.sv
`timescale 1ns/1ps
module tb_ecc_scalar_mult_seq;
   localparam int N     = 32;
   localparam int KB    = 6;
   localparam int A     = 4;
   localparam int BOUND = 2*KB*(N+3)+3;

   logic                clk = 1'b0;
   logic                rst, start, busy, done, err;
   logic [KB-1:0]       k;
   logic signed [N-1:0] px, py, m, rx, ry;
   int                  n_vec = 0, n_bad = 0;

   ecc_scalar_mult_seq #(.NR_BITI(N), .K_BITS(KB), .COEF_A(A)) dut (
      .clk(clk), .rst(rst), .start(start), .k(k), .px(px), .py(py), .m(m),
      .busy(busy), .done(done), .err(err), .rx(rx), .ry(ry)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model: textbook affine arithmetic ----------------
   typedef struct { longint x; longint y; } mpt_t;

   function automatic longint md(input longint v, input longint mm);
      longint r = v % mm;
      return (r < 0) ? r + mm : r;
   endfunction

   // Extended Euclid; 0 has no inverse and maps to 0 (as 0^(m-2) does).
   function automatic longint minv(input longint a, input longint mm);
      longint t = 0, nt = 1, r = mm, nr = a, q, tmp;
      if (a == 0) return 0;
      while (nr != 0) begin
         q = r / nr;
         tmp = t - q*nt; t = nt; nt = tmp;
         tmp = r - q*nr; r = nr; nr = tmp;
      end
      return md(t, mm);
   endfunction

   function automatic mpt_t chord(input longint num, den, x1, y1, x2, mm);
      mpt_t   o;
      longint lam = md(num * minv(den, mm), mm);
      o.x = md(lam*lam - x1 - x2, mm);
      o.y = md(lam*(x1 - o.x) - y1, mm);
      return o;
   endfunction

   function automatic mpt_t pdbl(input mpt_t r, input longint mm);
      mpt_t z = '{0, 0};
      if (r.x == 0 && r.y == 0) return r;
      if (r.y == 0) return z;
      return chord(md(3*md(r.x*r.x, mm) + A, mm), md(2*r.y, mm), r.x, r.y, r.x, mm);
   endfunction

   function automatic mpt_t padd(input mpt_t r, input mpt_t p, input longint mm);
      mpt_t z = '{0, 0};
      if (r.x == 0 && r.y == 0) return p;
      if (p.x == 0 && p.y == 0) return r;
      if (r.x == p.x && r.y == md(mm - p.y, mm)) return z;
      return chord(md(p.y - r.y, mm), md(p.x - r.x, mm), r.x, r.y, p.x, mm);
   endfunction

   function automatic mpt_t smul(input logic [KB-1:0] kk, input mpt_t p, input longint mm);
      mpt_t r = '{0, 0};
      for (int i = KB-1; i >= 0; i--) begin
         r = pdbl(r, mm);
         if (kk[i]) r = padd(r, p, mm);
      end
      return r;
   endfunction

   // ---------------- driver ----------------
   // poke > 0 re-pulses start (with an illegal modulus) at that cycle while busy.
   task automatic run(input logic [KB-1:0] kk, input longint x, y, mm, input int poke,
                      output int lat, output bit got);
      @(negedge clk);
      k = kk; px = N'(x); py = N'(y); m = N'(mm); start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1;
      k = ~kk; px = '0; py = '0; m = 2;          // captured copies must be used
      while (!done && lat < BOUND + 10) begin
         if (lat == poke) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      got = done;
   endtask

   task automatic check_run(input string tag, input logic [KB-1:0] kk, input longint x, y, mm,
                            input longint ex, ey, input bit eerr, input int lim, input int poke);
      int lat; bit got;
      run(kk, x, y, mm, poke, lat, got);
      chk({tag, " done seen"}, longint'(got), 1);
      if (got) begin
         chk({tag, " rx"}, rx, ex);
         chk({tag, " ry"}, ry, ey);
         chk({tag, " err"}, longint'(err), longint'(eerr));
         n_vec++;
         if (lat > lim) begin
            n_bad++;
            $display("FAIL %s latency: got %0d, want <= %0d", tag, lat, lim);
         end
         @(negedge clk);
         chk({tag, " done one cycle"}, longint'(done), 0);
         chk({tag, " busy low after"}, longint'(busy), 0);
         chk({tag, " rx held"}, rx, ex);
      end
   endtask

   typedef struct {
      string         tag;
      logic [KB-1:0] kk;
      longint        x, y, mm, ex, ey;
      bit            eerr;
      int            lim;
   } vec_t;

   initial begin
      vec_t   tbl[7];
      longint primes[6] = '{97, 101, 251, 65521, 1000003, 2147483647};
      bit     seen;

      tbl[0] = '{"k1",     1, 1, 2, 97,  1,  2, 1'b0, BOUND};
      tbl[1] = '{"k2",     2, 1, 2, 97, 92, 57, 1'b0, BOUND};
      tbl[2] = '{"k3",     3, 1, 2, 97, 53, 22, 1'b0, BOUND};
      tbl[3] = '{"k0",     0, 1, 2, 97,  0,  0, 1'b0, BOUND};
      tbl[4] = '{"y0dbl",  2, 5, 0, 97,  0,  0, 1'b0, BOUND};
      tbl[5] = '{"m2",     5, 1, 1,  2,  0,  0, 1'b1, 3};
      tbl[6] = '{"m1",    63, 0, 0,  1,  0,  0, 1'b1, 3};

      rst = 1'b1; start = 1'b0; k = '0; px = '0; py = '0; m = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", longint'(busy), 0);
      chk("reset done", longint'(done), 0);
      chk("reset err",  longint'(err), 0);
      chk("reset rx", rx, 0);
      chk("reset ry", ry, 0);
      rst = 1'b0;

      foreach (tbl[i])
         check_run(tbl[i].tag, tbl[i].kk, tbl[i].x, tbl[i].y, tbl[i].mm,
                   tbl[i].ex, tbl[i].ey, tbl[i].eerr, tbl[i].lim, 0);

      // start while busy must be ignored
      check_run("k3 restart ignored", 3, 1, 2, 97, 53, 22, 1'b0, BOUND, 15);

      // reset in the middle of an inversion aborts silently
      @(negedge clk);
      k = 3; px = 1; py = 2; m = 97; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst busy", longint'(busy), 0);
      chk("midrst rx", rx, 0);
      chk("midrst ry", ry, 0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("midrst no activity", longint'(seen), 0);
      check_run("after rst k2", 2, 1, 2, 97, 92, 57, 1'b0, BOUND, 0);

      // randomized points/scalars against the model
      for (int n = 0; n < 16; n++) begin
         longint  mm, x, y;
         logic [KB-1:0] kk;
         mpt_t    e;
         int      sel;
         mm  = primes[$urandom_range(0, 5)];
         x   = longint'($urandom) % mm;
         y   = longint'($urandom) % mm;
         sel = $urandom_range(0, 7);
         if (sel == 0) begin x = 0; y = 0; end
         if (sel == 1) y = 0;
         kk = KB'($urandom);
         e  = smul(kk, '{x, y}, mm);
         check_run($sformatf("rnd%0d m=%0d k=%0d P=(%0d,%0d)", n, mm, kk, x, y),
                   kk, x, y, mm, e.x, e.y, 1'b0, BOUND, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
